// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] DIGITS_OFF = '1;

    // Bit i set when digit i and every more-significant digit are zero; digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] blank_vec(
        input logic [BCD_W*MAX_DIGITS-1:0] word,
        input int unsigned                 num_digits
    );
        logic [MAX_DIGITS-1:0] blank;
        logic                  upper_zero;
        int unsigned           j;
        blank      = '0;
        upper_zero = 1'b1;
        for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
            j = MAX_DIGITS - 1 - k;
            if (j < num_digits) begin
                upper_zero = upper_zero & (word[j*BCD_W +: BCD_W] == '0);
                blank[j]   = upper_zero;
            end
        end
        blank[0] = 1'b0;
        return blank;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Per-digit slot counter with end-of-guard and end-of-slot strobes.
module seg_scan_timer #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic guard_end_o,
    output logic slot_end_o,
    output logic last_next_o
);

    localparam int unsigned        CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign slot_end_o  = (cnt_q == SLOT_LAST);
    assign guard_end_o = (GUARD_CYCLES != 0) && (cnt_q == GUARD_LAST);

    always_comb begin
        cnt_d = slot_end_o ? '0 : cnt_q + 1'b1;
    end

    // Lets the parent register strobes that must coincide with the last slot cycle.
    assign last_next_o = (cnt_d == SLOT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed scan controller for NUM_DIGITS common-anode digits with frame-synchronous word commit.
// Optional leading-zero blanking: define SEG_SCAN_BLANK_EN.
module seven_seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_data,
    output logic [BCD_W-1:0]              bcd_out,
    output logic                          lz_out,
    output logic [NUM_DIGITS-1:0]         digit_an_n,
    output logic                          frame_done
);

    localparam int unsigned        IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                  state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [BCD_W*NUM_DIGITS-1:0]  active_q, active_d, shadow_q, shadow_d;
    logic                         pending_q, pending_d;
    logic                         ready_q, ready_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic [BCD_W-1:0]             bcd_q, bcd_d;
    logic                         fd_q, fd_d;
    logic                         guard_end, slot_end, last_next;
    logic                         accept, commit;

    seg_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .guard_end_o (guard_end),
        .slot_end_o  (slot_end),
        .last_next_o (last_next)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            GUARD: if (GUARD_CYCLES == 0 || guard_end) state_d = SHOW;
            SHOW: begin
                if (slot_end) begin
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (GUARD_CYCLES != 0) state_d = GUARD;
                end
            end
            default: state_d = GUARD;
        endcase
    end

    always_comb begin
        accept    = load_valid & ~pending_q;
        commit    = fd_q & pending_q;
        shadow_d  = accept ? load_data : shadow_q;
        active_d  = commit ? shadow_q : active_q;
        pending_d = pending_q;
        if (accept)      pending_d = 1'b1;
        else if (commit) pending_d = 1'b0;
        ready_d = ~pending_d;

        // Outputs come from next-state values so the registered pins line up with state_q;
        // active only changes at a slot boundary, so bcd holds steady across guard and show.
        an_d = DIGITS_OFF[NUM_DIGITS-1:0];
        if (state_d == SHOW) an_d[idx_d] = 1'b0;
        bcd_d = active_d[idx_d*BCD_W +: BCD_W];
        fd_d  = last_next & (idx_d == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= GUARD;
            idx_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            an_q      <= DIGITS_OFF[NUM_DIGITS-1:0];
            bcd_q     <= '0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
            fd_q      <= fd_d;
        end
    end

    assign load_ready = ready_q;
    assign bcd_out    = bcd_q;
    assign digit_an_n = an_q;
    assign frame_done = fd_q;

`ifdef SEG_SCAN_BLANK_EN
    logic                          lz_q, lz_d;
    logic [BCD_W*MAX_DIGITS-1:0]   word_ext;
    logic [MAX_DIGITS-1:0]         blank_d;

    always_comb begin
        word_ext                          = '0;
        word_ext[BCD_W*NUM_DIGITS-1:0]    = active_d;
        blank_d                           = blank_vec(word_ext, NUM_DIGITS);
        lz_d                              = blank_d[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lz_q <= 1'b0;
        else        lz_q <= lz_d;
    end

    assign lz_out = lz_q;
`else
    assign lz_out = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Self-checking bench for seven_seg_scan_controller (NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2).
module tb_seven_seg_scan_controller;

    localparam int unsigned ND    = 4;
    localparam int unsigned DIV   = 8;
    localparam int unsigned GC    = 2;
    localparam int unsigned FRAME = ND * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  bcd_out;
    logic        lz_out;
    logic [3:0]  digit_an_n;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scan_controller #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (DIV),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bcd_out    (bcd_out),
        .lz_out     (lz_out),
        .digit_an_n (digit_an_n),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] nib;
        logic [3:0]  lz;
    } frame_t;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  lz;
    } vec_t;

    frame_t exp_q[$];
    frame_t cur;
    vec_t   vecs[6];

    task automatic check(input string name, input int unsigned cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] eff_lz(input logic [3:0] lz);
`ifdef SEG_SCAN_BLANK_EN
        return lz;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic frame_t mk(input logic [15:0] w, input logic [3:0] lz);
        frame_t f;
        f.nib = w;
        f.lz  = eff_lz(lz);
        return f;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 0, load_ready, 1);
        check({tag, "_bcd"},   0, bcd_out, 0);
        check({tag, "_lz"},    0, lz_out, 0);
        check({tag, "_an"},    0, digit_an_n, 4'hF);
        check({tag, "_fd"},    0, frame_done, 0);
    endtask

    // One full frame, sampled on each falling edge, starting just before cycle 0's falling edge.
    task automatic capture(input frame_t e, input bit chk_rdy);
        for (int unsigned c = 0; c < FRAME; c++) begin
            int unsigned d;
            int unsigned s;
            logic [3:0]  exp_an;
            @(negedge clk);
            d      = c / DIV;
            s      = c % DIV;
            exp_an = 4'hF;
            if (s >= GC) exp_an[d] = 1'b0;
            check("digit_an_n", c, digit_an_n, exp_an);
            check("frame_done", c, frame_done, (c == FRAME - 1));
            check("bcd_out",    c, bcd_out, e.nib[d*4 +: 4]);
            check("lz_out",     c, lz_out, e.lz[d]);
            if (chk_rdy) check("load_ready", c, load_ready, 1);
        end
    endtask

    // Called at a falling edge; pushes the expected frame when the transfer happens.
    task automatic load_word(input logic [15:0] w, input frame_t e, input bit hold);
        bit done;
        bit rdy;
        done       = 1'b0;
        load_data  = w;
        load_valid = 1'b1;
        for (int unsigned t = 0; t < 200 && !done; t++) begin
            rdy = load_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
                exp_q.push_back(e);
                #1 load_valid = hold;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL load_timeout word=%h got=no_transfer exp=transfer", w);
            load_valid = 1'b0;
        end else begin
            @(negedge clk);
            check("ready_fall", 0, load_ready, 0);
        end
    endtask

    task automatic pop_cur();
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=0 exp=1");
        end else begin
            cur = exp_q.pop_front();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{word: 16'h0042, lz: 4'b1100};
        vecs[1] = '{word: 16'h1000, lz: 4'b0000};
        vecs[2] = '{word: 16'h0007, lz: 4'b1110};
        vecs[3] = '{word: 16'h00A0, lz: 4'b1100};
        vecs[4] = '{word: 16'h0305, lz: 4'b1000};
        vecs[5] = '{word: 16'h0000, lz: 4'b1110};

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        cur = mk(16'h0000, 4'b1110);
        capture(cur, 1'b1);

        for (int unsigned v = 0; v < 6; v++) begin
            fork
                capture(cur, 1'b0);
                begin
                    repeat (13) @(negedge clk);
                    load_word(vecs[v].word, mk(vecs[v].word, vecs[v].lz), 1'b0);
                end
            join
            pop_cur();
            capture(cur, 1'b1);
        end

        // Back-to-back offers: the second waits for ready after the first commits.
        fork
            begin
                capture(cur, 1'b0);
                pop_cur();
                capture(cur, 1'b0);
            end
            begin
                repeat (11) @(negedge clk);
                load_word(16'h1234, mk(16'h1234, 4'b0000), 1'b1);
                load_word(16'h5678, mk(16'h5678, 4'b0000), 1'b0);
            end
        join
        pop_cur();
        capture(cur, 1'b1);

        // Transfer during the frame_done cycle commits one boundary later.
        fork
            begin
                capture(cur, 1'b0);
                capture(cur, 1'b0);
                pop_cur();
                capture(cur, 1'b1);
            end
            begin
                repeat (32) @(negedge clk);
                load_word(16'h0090, mk(16'h0090, 4'b1100), 1'b0);
            end
        join

        // Reset during SHOW of digit 2 with a pending word.
        repeat (6) @(negedge clk);
        load_word(16'h9999, mk(16'h9999, 4'b0000), 1'b0);
        repeat (14) @(negedge clk);
        check("an_pre_reset", 20, digit_an_n, 4'b1011);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_reset_vals("midrst_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cur = mk(16'h0000, 4'b1110);
        capture(cur, 1'b1);
        capture(cur, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
